// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode constants, fetch FSM states, reset PC.
package mips_pkg;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned OPCODE_WIDTH = 6;
   localparam int unsigned IMM_WIDTH = 16;

   localparam logic [DATA_WIDTH-1:0] PC_RESET_DEFAULT = 32'h0040_0000;

   localparam logic [OPCODE_WIDTH-1:0] R_TYPE = 6'h00;
   localparam logic [OPCODE_WIDTH-1:0] BEQ    = 6'h04;
   localparam logic [OPCODE_WIDTH-1:0] BNE    = 6'h05;
   localparam logic [OPCODE_WIDTH-1:0] ADDI   = 6'h08;
   localparam logic [OPCODE_WIDTH-1:0] ORI    = 6'h0d;
   localparam logic [OPCODE_WIDTH-1:0] LUI    = 6'h0f;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2
   } fetchState_e;

endpackage

// File: rtl/branch_target.sv
// Branch target adder: pc_plus4 + (sign-extended imm16 << 2), modulo 2^DATA_WIDTH.
// Ports:
//   pc_plus4  in   address of the instruction after the branch
//   imm16     in   16-bit immediate field of the branch
//   target    out  branch destination address
//   signExt   out  imm16 sign-extended to DATA_WIDTH (shared with jump logic)
module branch_target #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] pc_plus4,
   input  logic [15:0]           imm16,
   output logic [DATA_WIDTH-1:0] target,
   output logic [DATA_WIDTH-1:0] signExt
);

   always_comb begin
      signExt = {{(DATA_WIDTH-16){imm16[15]}}, imm16};
      target  = pc_plus4 + {signExt[DATA_WIDTH-3:0], 2'b00};
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a
// req/ack handshake, presents it to the decoder and picks the next PC from
// the decoder's branch controls and the ALU zero flag.
// Ports:
//   clk, reset            clock, async active-low reset
//   imem_req/imem_addr    fetch request and word byte address (= pc)
//   imem_ack/imem_rdata   memory response
//   instr_valid/instr     held instruction for the decoder
//   opcode                instr[31:26]
//   pc_out/pc_plus4       address of held instruction and +4
//   stall                 downstream hold
//   branch_eq/branch_ne   decoder branch controls
//   zero                  ALU zero flag
//   retired               instructions accepted since reset
module instruction_fetch_unit
   import mips_pkg::*;
#(
   parameter int unsigned            DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0]  PC_RESET   = DATA_WIDTH'(PC_RESET_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_ack,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  instr_valid,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [5:0]            opcode,
   output logic [DATA_WIDTH-1:0] pc_out,
   output logic [DATA_WIDTH-1:0] pc_plus4,
   input  logic                  stall,
   input  logic                  branch_eq,
   input  logic                  branch_ne,
   input  logic                  zero,
   output logic [DATA_WIDTH-1:0] retired
);

   fetchState_e           state, nextState;
   logic [DATA_WIDTH-1:0] pc, nextPc;
   logic [DATA_WIDTH-1:0] nextInstr, nextRetired;
   logic [DATA_WIDTH-1:0] branchTarget;
   logic [DATA_WIDTH-1:0] unusedSignExt;  // consumed only by the jump path
   logic                  taken;

   branch_target #(.DATA_WIDTH(DATA_WIDTH)) u_branch_target (
      .pc_plus4 (pc_plus4),
      .imm16    (instr[15:0]),
      .target   (branchTarget),
      .signExt  (unusedSignExt)
   );

   // Combinational views of the held instruction and PC
   always_comb begin
      opcode    = instr[DATA_WIDTH-1:DATA_WIDTH-6];
      pc_plus4  = pc + DATA_WIDTH'(4);
      imem_addr = pc;
      pc_out    = pc;
      taken     = (branch_eq & zero) | (branch_ne & ~zero);
   end

   // Next-state and next-register logic
   always_comb begin
      nextState   = state;
      nextPc      = pc;
      nextInstr   = instr;
      nextRetired = retired;
      case (state)
         IDLE: nextState = FETCH;
         FETCH: begin
            if (imem_ack) begin
               nextInstr = imem_rdata;
               nextState = ISSUE;
            end
         end
         ISSUE: begin
            if (!stall) begin
               nextPc      = taken ? branchTarget : pc_plus4;
               nextRetired = retired + DATA_WIDTH'(1);
               nextState   = FETCH;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // State and registered outputs; req/valid are decoded from the next state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         pc          <= PC_RESET;
         instr       <= '0;
         retired     <= '0;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
      end else begin
         state       <= nextState;
         pc          <= nextPc;
         instr       <= nextInstr;
         retired     <= nextRetired;
         imem_req    <= (nextState == FETCH);
         instr_valid <= (nextState == ISSUE);
      end
   end

endmodule
